// File: rtl/bbtron_pkg.sv
// rtl/bbtron_pkg.sv - shared state, opcode and aluOp encodings for the sequencer
// Purpose : common types and constants imported by the cpu_sequencer slice.
// Contents: state_t encoding, opcode limits, mul/div/rem aluOp codes,
//           is_muldiv() helper.
package bbtron_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_WAIT_IN = 3'd5,
    ST_HALT    = 3'd6
  } state_t;

  localparam logic [5:0] OP_RESET = 6'b011001;
  // Highest defined opcode; anything above it is illegal.
  localparam logic [5:0] OP_LAST  = OP_RESET;

  localparam logic [3:0] ALU_MUL = 4'b1100;
  localparam logic [3:0] ALU_DIV = 4'b1101;
  localparam logic [3:0] ALU_REM = 4'b1110;

  function automatic logic is_muldiv(input logic [3:0] alu_op);
    return (alu_op == ALU_MUL) || (alu_op == ALU_DIV) || (alu_op == ALU_REM);
  endfunction

endpackage

// File: rtl/seq_stall_counter.sv
// rtl/seq_stall_counter.sv - loadable 4-bit down-counter with zero flag
// Purpose : holds the EXEC wait-state count for multi-cycle ALU ops.
// Ports   : clk, rst_n (async, active-low)
//           i_load / i_load_val : load a new count (load wins over decrement)
//           i_dec               : decrement, stops at zero
//           o_zero              : count is zero
module seq_stall_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle instruction sequencer producing datapath phase strobes
// Purpose : FETCH/DECODE/EXEC/MEM/WB/WAIT_IN/HALT sequencing from decoded control levels.
// Inputs  : clk, rst_n (async, active-low), opcode, cu_* decoded levels,
//           in_valid / resume one-cycle pulses.
// Outputs : ir_load, pc_en, pc_clr, reg_we, dmem_re, dmem_we, in_ack, disp_load,
//           sys_rst strobes; halted level; sticky illegal; state; saturating retired.
module cpu_sequencer
  import bbtron_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [3:0]       cu_aluOp,
  input  logic             cu_writeReg,
  input  logic             cu_readEnable,
  input  logic             cu_writeEnable,
  input  logic             cu_Branch,
  input  logic             cu_Jump,
  input  logic             cu_inSignal,
  input  logic             cu_showDisplay,
  input  logic             cu_hlt,
  input  logic             cu_reset,
  input  logic             in_valid,
  input  logic             resume,
  output logic             ir_load,
  output logic             pc_en,
  output logic             pc_clr,
  output logic             reg_we,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             in_ack,
  output logic             disp_load,
  output logic             sys_rst,
  output logic             halted,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] LAT = 4'(MULDIV_LAT);

  state_t           r_state;
  state_t           w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  logic w_ir_load, w_pc_en, w_pc_clr, w_reg_we, w_dmem_re, w_dmem_we;
  logic w_in_ack, w_disp_load, w_sys_rst, w_set_illegal;
  logic w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic [3:0] w_cnt_val;

  seq_stall_counter u_stall (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_ir_load     = 1'b0;
    w_pc_en       = 1'b0;
    w_pc_clr      = 1'b0;
    w_reg_we      = 1'b0;
    w_dmem_re     = 1'b0;
    w_dmem_we     = 1'b0;
    w_in_ack      = 1'b0;
    w_disp_load   = 1'b0;
    w_sys_rst     = 1'b0;
    w_set_illegal = 1'b0;
    w_cnt_load    = 1'b0;
    w_cnt_val     = 4'd0;
    w_cnt_dec     = 1'b0;

    unique case (r_state)
      ST_FETCH: begin
        w_ir_load = 1'b1;
        w_next    = ST_DECODE;
      end
      ST_DECODE: begin
        if (opcode > OP_LAST) begin
          w_set_illegal = 1'b1;
          w_next        = ST_HALT;
        end else if (cu_reset) begin
          w_sys_rst = 1'b1;
          w_pc_clr  = 1'b1;
          w_next    = ST_FETCH;
        end else if (cu_hlt) begin
          w_next = ST_HALT;
        end else if (cu_inSignal) begin
          w_next = ST_WAIT_IN;
        end else begin
          w_cnt_load = 1'b1;
          w_cnt_val  = is_muldiv(cu_aluOp) ? LAT : 4'd0;
          w_next     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!w_cnt_zero) begin
          w_cnt_dec = 1'b1;
        end else if (cu_Jump || cu_Branch) begin
          // Tested first: memory enables are don't-care for control-flow opcodes.
          w_pc_en = 1'b1;
          w_next  = ST_FETCH;
        end else if (cu_readEnable || cu_writeEnable) begin
          w_next = ST_MEM;
        end else if (cu_showDisplay) begin
          w_disp_load = 1'b1;
          w_pc_en     = 1'b1;
          w_next      = ST_FETCH;
        end else begin
          w_next = ST_WB;
        end
      end
      ST_MEM: begin
        w_dmem_re = cu_readEnable;
        w_dmem_we = cu_writeEnable;
        if (cu_readEnable) begin
          w_next = ST_WB;
        end else begin
          w_pc_en = 1'b1;
          w_next  = ST_FETCH;
        end
      end
      ST_WB: begin
        w_reg_we = cu_writeReg;
        w_pc_en  = 1'b1;
        w_next   = ST_FETCH;
      end
      ST_WAIT_IN: begin
        if (in_valid) begin
          w_in_ack = 1'b1;
          w_next   = ST_WB;
        end
      end
      ST_HALT: begin
        if (resume) begin
          w_pc_en = 1'b1;
          w_next  = ST_FETCH;
        end
      end
      default: begin
        w_next = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (w_set_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_sys_rst) begin
      r_retired <= '0;
    end else if (w_pc_en && !(&r_retired)) begin
      r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Gating with rst_n keeps the FETCH decode (ir_load) quiet while reset is held.
  assign ir_load   = w_ir_load   & rst_n;
  assign pc_en     = w_pc_en     & rst_n;
  assign pc_clr    = w_pc_clr    & rst_n;
  assign reg_we    = w_reg_we    & rst_n;
  assign dmem_re   = w_dmem_re   & rst_n;
  assign dmem_we   = w_dmem_we   & rst_n;
  assign in_ack    = w_in_ack    & rst_n;
  assign disp_load = w_disp_load & rst_n;
  assign sys_rst   = w_sys_rst   & rst_n;
  assign halted    = (r_state == ST_HALT) & rst_n;
  assign illegal   = r_illegal;
  assign state     = r_state;
  assign retired   = r_retired;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle instruction sequencer for the processor datapath. Sits beside the opcode decoder, consumes its decoded control levels, and turns them into one-cycle phase strobes for the datapath:

- IR load
- PC advance
- register write
- data-memory read/write
- display load

It adds wait states for multiply/divide/remainder, blocks on the IN handshake, and implements halt, resume and the software-reset opcode. It also keeps a retired-instruction count.

## Interface
Parameters:
- MULDIV_LAT, 4: extra EXEC wait cycles for aluOp 1100/1101/1110 (1..15)
- CNT_W, 16: retired-instruction counter width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- opcode  in  6  current IR opcode
- cu_aluOp  in  4  decoded ALU operation
- cu_writeReg, cu_readEnable, cu_writeEnable, cu_Branch, cu_Jump, cu_inSignal, cu_showDisplay, cu_hlt, cu_reset  in  1 each  decoded control levels
- in_valid  in  1  one-cycle pulse: input switches confirmed
- resume  in  1  one-cycle pulse: leave HALT
- ir_load  out  1  latch instruction into IR
- pc_en  out  1  PC takes next value (datapath selects +1/branch/jump)
- pc_clr  out  1  PC forced to 0
- reg_we  out  1  register-file write strobe
- dmem_re / dmem_we  out  1 each  data-memory strobes
- in_ack  out  1  input value accepted
- disp_load  out  1  display register load
- sys_rst  out  1  one-cycle soft reset to datapath registers
- halted  out  1  level, in HALT
- illegal  out  1  sticky, opcode > 6'b011001 seen
- state  out  3  current state encoding
- retired  out  CNT_W  completed instructions, saturating

## Operation
States:
- FETCH=0: ir_load=1 → DECODE.
- DECODE: evaluated in priority order.
  - opcode > 6'b011001: set illegal → HALT.
  - cu_reset: sys_rst=1, pc_clr=1, retired←0 → FETCH.
  - cu_hlt: → HALT.
  - cu_inSignal: → WAIT_IN.
  - Otherwise: wait counter ← MULDIV_LAT if cu_aluOp ∈ {1100,1101,1110}, else 0 → EXEC.
- EXEC: while counter ≠ 0, decrement and stay. At 0, priority order:
  - cu_Jump or cu_Branch: pc_en → FETCH.
  - cu_readEnable or cu_writeEnable: → MEM.
  - cu_showDisplay: disp_load, pc_en → FETCH.
  - Otherwise: → WB.
- MEM: dmem_re=cu_readEnable, dmem_we=cu_writeEnable.
  - Read: → WB.
  - Otherwise: pc_en → FETCH.
- WB: reg_we=cu_writeReg, pc_en → FETCH.
- WAIT_IN: stay until in_valid; then in_ack=1 → WB.
- HALT: halted=1. On resume: pc_en → FETCH. illegal stays set until rst_n.

Rules:
- Jump/Branch are tested before memory enables, because the decoder drives X on unused fields for those opcodes.
- reg_we, dmem_* and disp_load never assert outside WB, MEM and EXEC respectively.
- retired increments on every pc_en that completes an instruction, including HALT exit. It saturates at all-ones and is cleared by sys_rst.

## Timing
- All strobes are registered-state decodes. Each is high for exactly one cycle.
- Reset values: state=FETCH, illegal=0, retired=0, counter=0, halted=0. All strobes are combinational decodes and 0 during reset; ir_load rises the first cycle after rst_n deasserts.
- Cycles per instruction:
  - ALU reg/imm: 4
  - MUL/DIV/REM: 4+MULDIV_LAT
  - LW: 5
  - SW: 4
  - Branch/Jump/OUT: 3
  - IN: 4 + cycles waited in WAIT_IN
  - Reset opcode: 2
- in_valid/resume are ignored outside WAIT_IN/HALT, including the entry cycle's DECODE.
- rst_n asserted mid-instruction returns to FETCH immediately, with no strobe glitch.

## Structure
- Shared package bbtron_pkg holds:
  - state typedef and encodings
  - opcode constants (OP_RESET=6'b011001, OP_LAST)
  - aluOp constants (ALU_MUL=1100, ALU_DIV=1101, ALU_REM=1110)
- One sub-module, seq_stall_counter: loadable 4-bit down-counter with zero flag.

## Test plan
- Reset release, ADD opcode → ir_load @1, reg_we and pc_en @4, retired=1.
- MUL with MULDIV_LAT=4 → reg_we @8; no strobe during cycles 3–6.
- LW then SW → dmem_re @4 and reg_we @5; dmem_we @4 with reg_we never high.
- IN opcode, in_valid pulsed 10 cycles late (plus a stray pulse during DECODE) → stray ignored, in_ack then reg_we on the consecutive cycles after the real pulse.
- NOP/halt, resume 5 cycles later → halted high for 5 cycles, then pc_en, then FETCH. Opcode 6'b111111 → illegal=1, HALT.
- Reset opcode after 3 instructions → sys_rst and pc_clr for one cycle, retired=0. rst_n dropped during MUL wait → state=0 asynchronously.
